// File: rtl/imm_decode_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_decode_stage_pkg                                                       |
// | Shared constants, immediate-format enum and buffer entry struct.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package imm_decode_stage_pkg;

    localparam int WORD_SIZE_P  = 16;
    localparam int NUM_EXTENDED = 10;
    localparam int NUM_ARCH_REG = 8;

    // Same encoding the opcode decoder drives onto imm_sel.
    typedef enum logic [3:0] {
        IMM_ZX_7_0    = 4'd0,
        IMM_ZX_8_6    = 4'd1,
        IMM_ZX_6_0    = 4'd2,
        IMM_ZX_10_6   = 4'd3,
        IMM_SX_7_0    = 4'd4,
        IMM_SX_10_0   = 4'd5,
        IMM_SX_5_0    = 4'd6,
        IMM_ZX_6_3    = 4'd7,
        IMM_ZX_5_3    = 4'd8,
        IMM_STORE     = 4'd9,
        IMM_NONE      = 4'd15
    } imm_sel_e;

    typedef struct packed {
        logic [WORD_SIZE_P-1:0] instruction;
        logic [WORD_SIZE_P-1:0] pc;
        logic [WORD_SIZE_P-1:0] immediate;
        logic                   illegal;
    } imm_decode_entry_s;

endpackage
`default_nettype wire

// File: rtl/imm_decode_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_decode_stage_if                                                        |
// | Fetch-side and issue-side handshakes plus flush for the decode stage.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface imm_decode_stage_if;
    import imm_decode_stage_pkg::*;

    logic                   flush_i;
    logic                   valid_i;
    logic                   ready_o;
    logic [WORD_SIZE_P-1:0] instruction_i;
    logic [WORD_SIZE_P-1:0] pc_i;
    logic [3:0]             imm_sel_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [WORD_SIZE_P-1:0] instruction_o;
    logic [WORD_SIZE_P-1:0] pc_o;
    logic [WORD_SIZE_P-1:0] immediate_o;
    logic                   imm_illegal_o;

    modport master (
        output flush_i, valid_i, instruction_i, pc_i, imm_sel_i, ready_i,
        input  ready_o, valid_o, instruction_o, pc_o, immediate_o, imm_illegal_o
    );

    modport slave (
        input  flush_i, valid_i, instruction_i, pc_i, imm_sel_i, ready_i,
        output ready_o, valid_o, instruction_o, pc_o, immediate_o, imm_illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/imm_decode_stage_extension.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | extension                                                                  |
// | Produces all extended immediate formats from one instruction word.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module extension
    import imm_decode_stage_pkg::*;
(
    input  wire logic [WORD_SIZE_P-1:0]                  instruction,
    output logic      [NUM_EXTENDED-1:0][WORD_SIZE_P-1:0] extended
);

    always_comb begin
        extended[0] = {8'b0, instruction[7:0]};
        extended[1] = {13'b0, instruction[8:6]};
        extended[2] = {9'b0, instruction[6:0]};
        extended[3] = {11'b0, instruction[10:6]};
        extended[4] = {{8{instruction[7]}}, instruction[7:0]};
        extended[5] = {{5{instruction[10]}}, instruction[10:0]};
        extended[6] = {{10{instruction[5]}}, instruction[5:0]};
        extended[7] = {12'b0, instruction[6:3]};
        extended[8] = {13'b0, instruction[5:3]};
        extended[9] = {instruction[15:11], 8'b0, instruction[2:0]};
    end

endmodule
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_decode_stage                                                           |
// | Selects the immediate per instruction and queues results for issue.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int DEPTH_P = 2
) (
    input  wire logic          clk_i,
    input  wire logic          reset_i,
    imm_decode_stage_if.slave  bus
);

    localparam int c_PTR_W = $clog2(DEPTH_P);
    localparam int c_CNT_W = $clog2(DEPTH_P + 1);

    logic [NUM_EXTENDED-1:0][WORD_SIZE_P-1:0] w_ext;
    imm_decode_entry_s                        w_entry;
    imm_decode_entry_s                        r_mem [DEPTH_P];
    logic [c_PTR_W-1:0]                       r_head;
    logic [c_PTR_W-1:0]                       r_tail;
    logic [c_CNT_W-1:0]                       r_count;
    logic                                     w_ready;
    logic                                     w_valid;
    logic                                     w_enq;
    logic                                     w_deq;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH_P - 1)) ? '0 : p + 1'b1;
    endfunction

    extension u_extension (
        .instruction (bus.instruction_i),
        .extended    (w_ext)
    );

    always_comb begin
        w_entry.instruction = bus.instruction_i;
        w_entry.pc          = bus.pc_i;
        w_entry.immediate   = '0;
        w_entry.illegal     = 1'b0;
        if (bus.imm_sel_i < 4'(NUM_EXTENDED)) begin
            w_entry.immediate = w_ext[bus.imm_sel_i];
        end else if (bus.imm_sel_i != IMM_NONE) begin
            w_entry.illegal = 1'b1;
        end
    end

    // Handshake readiness comes only from registered occupancy, never from ready_i.
    assign w_ready = (r_count != c_CNT_W'(DEPTH_P));
    assign w_valid = (r_count != '0);
    assign w_enq   = bus.valid_i & w_ready & ~bus.flush_i;
    assign w_deq   = w_valid & bus.ready_i & ~bus.flush_i;

    always_ff @(posedge clk_i) begin
        if (reset_i || bus.flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= ptr_inc(r_tail);
            if (w_deq) r_head <= ptr_inc(r_head);
            if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
            else if (!w_enq && w_deq) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_tail] <= w_entry;
    end

    assign bus.ready_o       = w_ready;
    assign bus.valid_o       = w_valid;
    assign bus.instruction_o = r_mem[r_head].instruction;
    assign bus.pc_o          = r_mem[r_head].pc;
    assign bus.immediate_o   = r_mem[r_head].immediate;
    assign bus.imm_illegal_o = w_valid & r_mem[r_head].illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imm_decode_stage                                                        |
// | Directed self-checking bench for imm_decode_stage (DEPTH_P = 2).           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_imm_decode_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    imm_decode_stage_if bus ();

    imm_decode_stage #(.DEPTH_P(2)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i       = 1'b0;
        bus.valid_i       = 1'b0;
        bus.instruction_i = '0;
        bus.pc_i          = '0;
        bus.imm_sel_i     = 4'd15;
    endtask

    task automatic drive(input logic [15:0] instr, input logic [15:0] pc, input logic [3:0] sel);
        bus.valid_i       = 1'b1;
        bus.instruction_i = instr;
        bus.pc_i          = pc;
        bus.imm_sel_i     = sel;
    endtask

    // One instruction through an empty stage with ready_i high.
    task automatic single(input string tag, input logic [15:0] instr, input logic [3:0] sel,
                          input logic [15:0] exp_imm, input logic exp_ill);
        bus.ready_i = 1'b1;
        drive(instr, 16'h0040, sel);
        tick();
        idle_inputs();
        check({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
        check({tag, ".instr"}, 32'(bus.instruction_o), 32'(instr));
        check({tag, ".imm"}, 32'(bus.immediate_o), 32'(exp_imm));
        check({tag, ".ill"}, 32'(bus.imm_illegal_o), 32'(exp_ill));
        tick();
        check({tag, ".drained"}, 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        bus.ready_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset.ready", 32'(bus.ready_o), 32'd1);
        check("reset.valid", 32'(bus.valid_o), 32'd0);
        check("reset.ill", 32'(bus.imm_illegal_o), 32'd0);

        single("sel0", 16'h00FF, 4'd0, 16'h00FF, 1'b0);
        single("sel4", 16'h00FF, 4'd4, 16'hFFFF, 1'b0);
        single("sel6", 16'h00FF, 4'd6, 16'hFFFF, 1'b0);
        single("sel15", 16'h00FF, 4'd15, 16'h0000, 1'b0);
        single("sel9", 16'hF8FD, 4'd9, 16'hF805, 1'b0);
        single("sel5", 16'h0400, 4'd5, 16'hFC00, 1'b0);
        single("sel12", 16'h00FF, 4'd12, 16'h0000, 1'b1);
        single("sel1", 16'h01C0, 4'd1, 16'h0007, 1'b0);
        single("sel2", 16'h00FF, 4'd2, 16'h007F, 1'b0);
        single("sel3", 16'h07C0, 4'd3, 16'h001F, 1'b0);
        single("sel7", 16'h0078, 4'd7, 16'h000F, 1'b0);
        single("sel8", 16'h0038, 4'd8, 16'h0007, 1'b0);
        single("sel10", 16'h1234, 4'd10, 16'h0000, 1'b1);

        // Backpressure: three pushes with ready_i low.
        bus.ready_i = 1'b0;
        drive(16'hA001, 16'h0100, 4'd15);
        tick();
        check("bp.ready1", 32'(bus.ready_o), 32'd1);
        check("bp.head1", 32'(bus.pc_o), 32'h0100);
        drive(16'hA002, 16'h0102, 4'd15);
        tick();
        check("bp.ready2", 32'(bus.ready_o), 32'd0);
        drive(16'hA003, 16'h0104, 4'd15);
        tick();
        check("bp.held_ready", 32'(bus.ready_o), 32'd0);
        check("bp.stable_pc", 32'(bus.pc_o), 32'h0100);
        check("bp.stable_instr", 32'(bus.instruction_o), 32'hA001);
        bus.ready_i = 1'b1;
        tick();
        check("bp.drain_b", 32'(bus.pc_o), 32'h0102);
        check("bp.drain_ready", 32'(bus.ready_o), 32'd1);
        tick();
        idle_inputs();
        check("bp.drain_c", 32'(bus.pc_o), 32'h0104);
        check("bp.drain_c_instr", 32'(bus.instruction_o), 32'hA003);
        tick();
        check("bp.empty", 32'(bus.valid_o), 32'd0);

        // Streaming 20 instructions at one per cycle.
        bus.ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                check("stream.valid", 32'(bus.valid_o), 32'd1);
                check("stream.pc", 32'(bus.pc_o), 32'(16'h0200 + 16'(k - 1)));
            end
            check("stream.ready", 32'(bus.ready_o), 32'd1);
            drive(16'h1000 + 16'(k), 16'h0200 + 16'(k), 4'd15);
            tick();
        end
        idle_inputs();
        check("stream.last_pc", 32'(bus.pc_o), 32'h0213);
        check("stream.last_instr", 32'(bus.instruction_o), 32'h1013);
        tick();
        check("stream.empty", 32'(bus.valid_o), 32'd0);

        // Flush with the buffer full.
        bus.ready_i = 1'b0;
        drive(16'hB001, 16'h0300, 4'd0);
        tick();
        drive(16'hB002, 16'h0302, 4'd0);
        tick();
        check("flush.full", 32'(bus.ready_o), 32'd0);
        drive(16'hDEAD, 16'h0304, 4'd0);
        bus.flush_i = 1'b1;
        tick();
        idle_inputs();
        check("flush.valid", 32'(bus.valid_o), 32'd0);
        check("flush.ready", 32'(bus.ready_o), 32'd1);

        // Flush with one entry held: the same-cycle input must be dropped.
        drive(16'hC001, 16'h0400, 4'd0);
        tick();
        drive(16'hBEEF, 16'h0402, 4'd0);
        bus.flush_i = 1'b1;
        tick();
        idle_inputs();
        bus.ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("flush.no_output", 32'(bus.valid_o), 32'd0);
            tick();
        end

        // Reset mid-operation with count = 1.
        bus.ready_i = 1'b0;
        drive(16'hE001, 16'h0500, 4'd4);
        tick();
        check("rst_mid.count1", 32'(bus.valid_o), 32'd1);
        drive(16'hE002, 16'h0502, 4'd4);
        bus.ready_i = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check("rst_mid.valid", 32'(bus.valid_o), 32'd0);
        check("rst_mid.ready", 32'(bus.ready_o), 32'd1);
        check("rst_mid.ill", 32'(bus.imm_illegal_o), 32'd0);
        tick();
        check("rst_mid.stays_empty", 32'(bus.valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
